// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the fetch stage.
//   fetch_state_t : fetch FSM states (RUN, MISS, MISS_REDIR)
//   NOP_INSTR     : bubble instruction (addi x0,x0,0)
//   PC_STEP       : sequential fetch increment
//   pc_inc()      : 32-bit modulo PC+4
package fetch_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        MISS       = 2'd1,
        MISS_REDIR = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

    // Sequential successor address; wraps naturally at 2^32.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// if_id_reg: IF/ID pipeline register.
// Update priority each edge: flush -> bubble, stall -> hold,
// load -> capture fetched instruction, otherwise bubble.
// Ports:
//   clk_i, rst_n_i           clock, async active-low reset
//   flush_i, stall_i, load_i control from hazard unit / fetch FSM
//   instr_i, pc_i, pc_plus4_i fetched instruction and its addresses
//   instr_o, pc_o, pc_plus4_o, valid_o  registered IF/ID contents
module if_id_reg
    import fetch_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        flush_i,
    input  logic        stall_i,
    input  logic        load_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] pc_plus4_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o
);

    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic [31:0] r_pc_plus4;
    logic        r_valid;

    // IF/ID register: flush beats stall, stall beats load, idle inserts a bubble.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_instr    <= NOP_INSTR;
            r_pc       <= 32'd0;
            r_pc_plus4 <= 32'd0;
            r_valid    <= 1'b0;
        end else if (flush_i) begin
            r_instr    <= NOP_INSTR;
            r_pc       <= 32'd0;
            r_pc_plus4 <= 32'd0;
            r_valid    <= 1'b0;
        end else if (stall_i) begin
            r_instr    <= r_instr;
            r_pc       <= r_pc;
            r_pc_plus4 <= r_pc_plus4;
            r_valid    <= r_valid;
        end else if (load_i) begin
            r_instr    <= instr_i;
            r_pc       <= pc_i;
            r_pc_plus4 <= pc_plus4_i;
            r_valid    <= 1'b1;
        end else begin
            r_instr    <= NOP_INSTR;
            r_pc       <= 32'd0;
            r_pc_plus4 <= 32'd0;
            r_valid    <= 1'b0;
        end
    end

    assign instr_o    = r_instr;
    assign pc_o       = r_pc;
    assign pc_plus4_o = r_pc_plus4;
    assign valid_o    = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetch stage of the pipelined core.
// Owns the PC, drives the instruction memory address, tracks multi-cycle
// instruction misses and defers a redirect arriving mid-miss until the
// miss resolves. Fetched instructions are registered into IF/ID.
// Optional feature macro: FETCH_PERF_CNT_EN (performance counters; when
// undefined both counter ports read 0).
// Ports:
//   clk_i, rst_n_i                   clock, async active-low reset
//   stall_f_i, stall_d_i, flush_d_i  hazard unit controls
//   pc_src_e_i, pc_target_e_i        redirect from execute
//   instr_f_i, instr_miss_f_i        instruction memory return
//   pc_f_o                           fetch address
//   instr_d_o, pc_d_o, pc_plus4_d_o, valid_d_o   IF/ID contents
//   fetch_stall_o                    fetch not delivering (combinational)
//   fetch_count_o, miss_cycles_o     performance counters
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        stall_f_i,
    input  logic        stall_d_i,
    input  logic        flush_d_i,
    input  logic        pc_src_e_i,
    input  logic [31:0] pc_target_e_i,
    input  logic [31:0] instr_f_i,
    input  logic        instr_miss_f_i,
    output logic [31:0] pc_f_o,
    output logic [31:0] instr_d_o,
    output logic [31:0] pc_d_o,
    output logic [31:0] pc_plus4_d_o,
    output logic        valid_d_o,
    output logic        fetch_stall_o,
    output logic [31:0] fetch_count_o,
    output logic [31:0] miss_cycles_o
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_pend_pc;

    logic [31:0]  w_pc_plus4_f;
    logic         w_deliver_f;

    assign w_pc_plus4_f = pc_inc(r_pc);

    // F delivers only on a plain advance; in MISS_REDIR the returning data is wrong-path.
    assign w_deliver_f = (r_state != MISS_REDIR) & ~pc_src_e_i & ~instr_miss_f_i & ~stall_f_i;

    assign fetch_stall_o = instr_miss_f_i | (r_state == MISS_REDIR);

    // Fetch FSM with PC and pending-redirect registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= RUN;
            r_pc      <= RESET_PC;
            r_pend_pc <= 32'd0;
        end else begin
            case (r_state)
                RUN: begin
                    if (pc_src_e_i) begin
                        // Memory tolerates an address change mid-miss, so redirect wins.
                        r_pc    <= pc_target_e_i;
                        r_state <= RUN;
                    end else if (instr_miss_f_i) begin
                        r_pc    <= r_pc;
                        r_state <= MISS;
                    end else if (stall_f_i) begin
                        r_pc    <= r_pc;
                        r_state <= RUN;
                    end else begin
                        r_pc    <= w_pc_plus4_f;
                        r_state <= RUN;
                    end
                end
                MISS: begin
                    if (instr_miss_f_i) begin
                        r_pc <= r_pc;
                        if (pc_src_e_i) begin
                            // Defer the redirect until the outstanding miss resolves.
                            r_pend_pc <= pc_target_e_i;
                            r_state   <= MISS_REDIR;
                        end else begin
                            r_state   <= MISS;
                        end
                    end else if (pc_src_e_i) begin
                        r_pc    <= pc_target_e_i;
                        r_state <= RUN;
                    end else if (stall_f_i) begin
                        r_pc    <= r_pc;
                        r_state <= RUN;
                    end else begin
                        r_pc    <= w_pc_plus4_f;
                        r_state <= RUN;
                    end
                end
                MISS_REDIR: begin
                    if (instr_miss_f_i) begin
                        r_pc    <= r_pc;
                        r_state <= MISS_REDIR;
                        if (pc_src_e_i) begin
                            r_pend_pc <= pc_target_e_i;   // newest redirect wins
                        end else begin
                            r_pend_pc <= r_pend_pc;
                        end
                    end else begin
                        if (pc_src_e_i) begin
                            r_pc <= pc_target_e_i;
                        end else begin
                            r_pc <= r_pend_pc;
                        end
                        r_state <= RUN;
                    end
                end
                default: begin
                    r_state   <= RUN;
                    r_pc      <= RESET_PC;
                    r_pend_pc <= 32'd0;
                end
            endcase
        end
    end

    assign pc_f_o = r_pc;

    if_id_reg u_if_id_reg (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .flush_i    (flush_d_i),
        .stall_i    (stall_d_i),
        .load_i     (w_deliver_f),
        .instr_i    (instr_f_i),
        .pc_i       (r_pc),
        .pc_plus4_i (w_pc_plus4_f),
        .instr_o    (instr_d_o),
        .pc_o       (pc_d_o),
        .pc_plus4_o (pc_plus4_d_o),
        .valid_o    (valid_d_o)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_miss_cycles;
    logic        w_load_valid;

    // Counts only real instructions entering IF/ID, not held or flushed ones.
    assign w_load_valid = w_deliver_f & ~flush_d_i & ~stall_d_i;

    // Performance counters, free-running and wrapping at 2^32.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_fetch_count <= 32'd0;
            r_miss_cycles <= 32'd0;
        end else begin
            if (w_load_valid) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end else begin
                r_fetch_count <= r_fetch_count;
            end
            if (instr_miss_f_i) begin
                r_miss_cycles <= r_miss_cycles + 32'd1;
            end else begin
                r_miss_cycles <= r_miss_cycles;
            end
        end
    end

    assign fetch_count_o = r_fetch_count;
    assign miss_cycles_o = r_miss_cycles;
`else
    assign fetch_count_o = 32'd0;
    assign miss_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import fetch_pkg::*;

`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_f, stall_d, flush_d, pc_src;
    logic [31:0] pc_target, instr_f;
    logic        miss;
    logic [31:0] pc_f, instr_d, pc_d, pc_plus4_d, fetch_count, miss_cycles;
    logic        valid_d, fetch_stall;

    int n_checks = 0;
    int n_pass   = 0;

    fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .stall_f_i      (stall_f),
        .stall_d_i      (stall_d),
        .flush_d_i      (flush_d),
        .pc_src_e_i     (pc_src),
        .pc_target_e_i  (pc_target),
        .instr_f_i      (instr_f),
        .instr_miss_f_i (miss),
        .pc_f_o         (pc_f),
        .instr_d_o      (instr_d),
        .pc_d_o         (pc_d),
        .pc_plus4_d_o   (pc_plus4_d),
        .valid_d_o      (valid_d),
        .fetch_stall_o  (fetch_stall),
        .fetch_count_o  (fetch_count),
        .miss_cycles_o  (miss_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] e_instr,
                            input logic [31:0] e_pc, input logic e_valid);
        chk({tag, "_instr"}, instr_d, e_instr);
        chk({tag, "_pc"}, pc_d, e_pc);
        chk({tag, "_pc4"}, pc_plus4_d, (e_pc == 32'd0 && !e_valid) ? 32'd0 : e_pc + 32'd4);
        chk({tag, "_valid"}, {31'd0, valid_d}, {31'd0, e_valid});
    endtask

    task automatic chk_cnt(input string tag, input int e_fetch, input int e_miss);
        chk({tag, "_fcnt"}, fetch_count, PERF ? e_fetch : 32'd0);
        chk({tag, "_mcnt"}, miss_cycles, PERF ? e_miss : 32'd0);
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
        pc_src = 1'b0; pc_target = 32'd0; instr_f = 32'd0; miss = 1'b0;
        #12;
        chk("rst_pc", pc_f, 32'h100);
        chk_ifid("rst", NOP_INSTR, 32'd0, 1'b0);
        chk("rst_stall", {31'd0, fetch_stall}, 32'd0);
        chk_cnt("rst", 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Hit stream
        instr_f = 32'hC0DE_0100; step;
        chk("hit1_pc", pc_f, 32'h104);
        chk_ifid("hit1", 32'hC0DE_0100, 32'h100, 1'b1);
        instr_f = 32'hC0DE_0104; step;
        chk("hit2_pc", pc_f, 32'h108);
        chk_ifid("hit2", 32'hC0DE_0104, 32'h104, 1'b1);
        chk_cnt("hit2", 2, 0);

        // Three-cycle miss at 108
        miss = 1'b1; instr_f = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            #1 chk("miss_stall", {31'd0, fetch_stall}, 32'd1);
            step;
            chk("miss_pc", pc_f, 32'h108);
            chk_ifid("miss_bub", NOP_INSTR, 32'd0, 1'b0);
        end
        chk_cnt("miss3", 2, 3);
        miss = 1'b0; instr_f = 32'hC0DE_0108;
        #1 chk("miss_clr_stall", {31'd0, fetch_stall}, 32'd0);
        step;
        chk("miss_done_pc", pc_f, 32'h10C);
        chk_ifid("miss_done", 32'hC0DE_0108, 32'h108, 1'b1);
        chk_cnt("miss_done", 3, 3);

        // Redirect to 200 during a miss at 10C
        miss = 1'b1; step;
        pc_src = 1'b1; pc_target = 32'h200; step;
        chk("mr_hold_pc", pc_f, 32'h10C);
        pc_src = 1'b0;
        #1 chk("mr_stall_miss", {31'd0, fetch_stall}, 32'd1);
        step;
        chk("mr_hold2_pc", pc_f, 32'h10C);
        miss = 1'b0; instr_f = 32'hC0DE_010C;
        #1 chk("mr_stall_state", {31'd0, fetch_stall}, 32'd1);
        step;
        chk("mr_redir_pc", pc_f, 32'h200);
        chk_ifid("mr_discard", NOP_INSTR, 32'd0, 1'b0);
        chk_cnt("mr", 3, 6);
        chk("run_stall", {31'd0, fetch_stall}, 32'd0);

        // Redirect and miss in the same cycle while in RUN
        miss = 1'b1; pc_src = 1'b1; pc_target = 32'h300; step;
        chk("rm1_pc", pc_f, 32'h300);
        pc_target = 32'h400; step;   // still RUN, so the redirect is taken, not deferred
        chk("rm2_pc", pc_f, 32'h400);
        miss = 1'b0; pc_src = 1'b0; instr_f = 32'hC0DE_0400; step;
        chk("rm3_pc", pc_f, 32'h404);
        chk_ifid("rm3", 32'hC0DE_0400, 32'h400, 1'b1);
        chk_cnt("rm3", 4, 8);

        // Decode stall alone holds IF/ID, fetch stall holds PC, flush beats stall
        stall_d = 1'b1; instr_f = 32'hC0DE_0404; step;
        chk("sd_pc", pc_f, 32'h408);
        chk_ifid("sd_hold", 32'hC0DE_0400, 32'h400, 1'b1);
        stall_f = 1'b1; step;
        chk("sf_pc", pc_f, 32'h408);
        chk_ifid("sf_hold", 32'hC0DE_0400, 32'h400, 1'b1);
        flush_d = 1'b1; step;
        chk_ifid("flush", NOP_INSTR, 32'd0, 1'b0);
        stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0; instr_f = 32'hC0DE_0408; step;
        chk("post_flush_pc", pc_f, 32'h40C);
        chk_ifid("post_flush", 32'hC0DE_0408, 32'h408, 1'b1);
        chk_cnt("post_flush", 5, 8);

        // Reset while in MISS_REDIR
        miss = 1'b1; step;
        pc_src = 1'b1; pc_target = 32'h500; step;
        pc_src = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_pc", pc_f, 32'h100);
        chk_ifid("arst", NOP_INSTR, 32'd0, 1'b0);
        chk_cnt("arst", 0, 0);
        miss = 1'b0;
        #1 chk("arst_stall", {31'd0, fetch_stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; instr_f = 32'hC0DE_0100; step;
        chk("arst_restart_pc", pc_f, 32'h104);
        chk_ifid("arst_restart", 32'hC0DE_0100, 32'h100, 1'b1);

        // PC wrap at the top of the address space
        pc_src = 1'b1; pc_target = 32'hFFFF_FFFC; step;
        chk("wrap_tgt_pc", pc_f, 32'hFFFF_FFFC);
        pc_src = 1'b0; instr_f = 32'hC0DE_FFFC; step;
        chk("wrap_pc", pc_f, 32'h0);
        chk("wrap_instr", instr_d, 32'hC0DE_FFFC);
        chk("wrap_pcd", pc_d, 32'hFFFF_FFFC);
        chk("wrap_pc4", pc_plus4_d, 32'h0);
        chk("wrap_valid", {31'd0, valid_d}, 32'd1);
        chk_cnt("wrap", 2, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Fetch stage of the pipelined core: owns the PC register, drives the instruction memory/cache address, consumes its read data and miss status, and registers the fetched instruction into the IF/ID pipeline register. Sits directly upstream of the instruction memory, between the hazard unit (stall/flush) and decode. Holds fetch across multi-cycle instruction misses, inserts bubbles into decode, and defers a branch/jump redirect that arrives during a miss until the miss resolves.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk_i  input  1  core clock; all state updates on rising edge
- rst_n_i  input  1  asynchronous, active-low reset
- stall_f_i  input  1  hazard-unit fetch stall; hold PC
- stall_d_i  input  1  hazard-unit decode stall; hold IF/ID
- flush_d_i  input  1  hazard-unit decode flush; bubble IF/ID
- pc_src_e_i  input  1  redirect request from execute
- pc_target_e_i  input  32  redirect target
- instr_f_i  input  32  instruction read data for pc_f_o, same cycle
- instr_miss_f_i  input  1  instruction at pc_f_o not yet available
- pc_f_o  output  32  fetch address to instruction memory
- instr_d_o  output  32  IF/ID instruction
- pc_d_o  output  32  IF/ID PC
- pc_plus4_d_o  output  32  IF/ID PC+4
- valid_d_o  output  1  IF/ID holds a real instruction
- fetch_stall_o  output  1  fetch not delivering this cycle (to hazard unit)
- fetch_count_o  output  32  instructions delivered to decode
- miss_cycles_o  output  32  cycles with instr_miss_f_i high

## Operation
- States: RUN, MISS, MISS_REDIR.
- Priority per cycle: pc_src_e_i > instr_miss_f_i > stall_f_i > normal advance.
- RUN / MISS, no miss: redirect -> PC <= pc_target_e_i, F delivers nothing. Else stall_f_i -> hold PC. Else PC <= PC+4, F delivers instr_f_i, pc_f_o, pc_f_o+4. MISS returns to RUN.
- RUN, redirect with miss: redirect wins, PC <= target, stay RUN (memory tolerates address change mid-miss).
- RUN, miss, no redirect: hold PC, -> MISS.
- MISS, miss, no redirect: hold PC.
- MISS, miss, redirect: capture target in pend_pc, hold PC, -> MISS_REDIR.
- MISS_REDIR, miss: hold PC; a new redirect overwrites pend_pc (newest wins).
- MISS_REDIR, no miss: discard instr_f_i (wrong path), PC <= pend_pc, -> RUN. Redirect same cycle: PC <= pc_target_e_i instead.
- IF/ID update: flush_d_i -> bubble (flush beats stall_d_i). Else stall_d_i -> hold. Else F delivered -> load it, valid_d_o=1. Else bubble.
- Bubble: instr_d_o=32'h0000_0013 (addi x0,x0,0), pc_d_o=0, pc_plus4_d_o=0, valid_d_o=0.
- fetch_stall_o = instr_miss_f_i | (state==MISS_REDIR); combinational.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0. Target bits [1:0] are passed through unchecked.

## Timing
- Reset (async assert, sync to clk_i on release by top-level): PC=RESET_PC, state RUN, pend_pc=0, IF/ID = bubble, counters 0.
- pc_f_o is the PC register output; instr_f_i/instr_miss_f_i are combinational returns within the same cycle.
- Fetch-to-decode latency: 1 cycle. Redirect: pc_f_o = target the cycle after pc_src_e_i is sampled high.
- Hit stream: one instruction per cycle into IF/ID.
- N-cycle miss: N bubbles into decode (if not stalled), instruction delivered on the edge ending the first miss-free cycle.
- Reset asserted mid-miss or mid-MISS_REDIR: pending redirect dropped, fetch restarts at RESET_PC.

## Configuration
- FETCH_PERF_CNT_EN defined: fetch_count_o increments each edge a valid instruction loads IF/ID; miss_cycles_o increments each cycle instr_miss_f_i=1; both wrap at 2^32.
- Undefined: counter registers absent, both ports tied to 0; port list unchanged.

## Structure
- Shared package fetch_pkg: fetch_state_t enum (RUN, MISS, MISS_REDIR), NOP_INSTR = 32'h0000_0013.
- Sub-module if_id_reg: IF/ID register with flush/stall/load/bubble priority; FSM, PC and counters stay in fetch_unit.

## Test plan
- Reset, RESET_PC=32'h100, all hits, no stalls -> pc_f_o 100,104,108; IF/ID pc_d_o 100,104 one cycle later, valid_d_o=1, fetch_count_o=2 after two loads.
- Miss high 3 cycles at PC 32'h108 -> pc_f_o held 108, 3 bubbles (instr_d_o=0000_0013, valid 0), fetch_stall_o=1 for 3 cycles, miss_cycles_o=3, then instr at 108 loads.
- Redirect to 32'h200 during MISS at 32'h10C, miss clears 2 cycles later -> state MISS_REDIR, instr at 10C discarded, next pc_f_o=200, no wrong-path valid in decode.
- pc_src_e_i and instr_miss_f_i same cycle in RUN -> pc_f_o=target next cycle, state stays RUN.
- flush_d_i and stall_d_i together -> IF/ID bubble; stall_d_i alone -> IF/ID contents unchanged.
- rst_n_i pulsed low in MISS_REDIR -> outputs immediately reset values, pc_f_o=RESET_PC; PC 32'hFFFF_FFFC advance -> 0.
